// File: rtl/sim_test_monitor_if.sv
// Snoop bus from the cores into the test monitor, plus the monitor's SoC controls and verdict.
// Pure wiring, no latency of its own.
// No backpressure: the monitor samples every cycle and the cores never stall for it.
interface sim_test_monitor_if #(
  parameter int N_CH = 1
);
  // Per-core regfile write port and CSR sim-end flag
  logic [N_CH-1:0]    rf_we;
  logic [5*N_CH-1:0]  rf_waddr;
  logic [32*N_CH-1:0] rf_wdata;
  logic [N_CH-1:0]    mends;

  // SoC sequencing and verdict
  logic               soc_rst_n;
  logic               ex_trap;
  logic               done;
  logic               pass;
  logic               fail;
  logic               timeout;
  logic               mends_end;
  logic [N_CH-1:0]    fail_ch;
  logic [31:0]        fail_num;

  // Core side drives the snoop bus and observes the verdict
  modport master (
    output rf_we, rf_waddr, rf_wdata, mends,
    input  soc_rst_n, ex_trap, done, pass, fail, timeout, mends_end, fail_ch, fail_num
  );

  // Monitor side
  modport slave (
    input  rf_we, rf_waddr, rf_wdata, mends,
    output soc_rst_n, ex_trap, done, pass, fail, timeout, mends_end, fail_ch, fail_num
  );
endinterface

// File: rtl/sim_test_monitor.sv
// Multi-channel test-result monitor: sequences SoC reset and trap stimulus, judges PASS/FAIL/MENDS/TIMEOUT.
// End condition is seen one cycle after the write/flag; the verdict follows DRAIN_CYC cycles later.
// No backpressure: snoops the cores passively, and the verdict stays sticky until rst.
module sim_test_monitor #(
  parameter int N_CH      = 1,
  parameter int ISA_TEST  = 1,
  parameter int DONE_REG  = 26,
  parameter int PASS_REG  = 27,
  parameter int NUM_REG   = 3,
  parameter int RST_CYC   = 10,
  parameter int TRAP_DLY  = 30,
  parameter int TRAP_LEN  = 7,
  parameter int DRAIN_CYC = 10,
  parameter int TIMEOUT   = 30000
) (
  input logic               clk,
  input logic               rst,
  sim_test_monitor_if.slave mon
);

  localparam int CW = $clog2(TIMEOUT + TRAP_DLY + TRAP_LEN + 1);
  localparam int HW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [4:0]    DONE_IDX = 5'(DONE_REG);
  localparam logic [4:0]    PASS_IDX = 5'(PASS_REG);
  localparam logic [4:0]    NUM_IDX  = 5'(NUM_REG);
  localparam logic [HW-1:0] RST_LAST = HW'(RST_CYC - 1);
  localparam logic [DW-1:0] DR_LAST  = DW'(DRAIN_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  // Trap window [WIN_LO, WIN_HI); an empty window when TRAP_LEN is 0
  localparam logic [CW:0]   WIN_LO   = (CW+1)'(TRAP_DLY);
  localparam logic [CW:0]   WIN_HI   = (CW+1)'(TRAP_DLY + TRAP_LEN);

  typedef enum logic [1:0] {HOLD, RUN, DRAIN, DONE} state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   drain_cnt;
  logic            done_chk;
  logic            mends_hit;

  logic [N_CH-1:0] done_sh;
  logic [N_CH-1:0] pass_sh;
  logic [31:0]     num_sh [N_CH];
  logic            mends_q;

  logic            all_done;
  logic            end_now;
  logic [N_CH-1:0] fail_mask;
  logic [31:0]     first_num;
  logic [CW:0]     cnt_nxt;

  function automatic logic in_win(input logic [CW:0] v);
    return (v >= WIN_LO) && (v < WIN_HI);
  endfunction

  assign all_done  = &done_sh;
  assign end_now   = ((ISA_TEST != 0) && all_done) || mends_q;
  assign fail_mask = ~pass_sh;
  assign cnt_nxt   = {1'b0, cnt} + (CW+1)'(1);

  // NUM shadow of the lowest-index failing channel, zero when every channel passed
  always_comb begin
    first_num = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (fail_mask[k]) first_num = num_sh[k];
    end
  end

  // Shadow the result registers and the mends flag while the test is running or draining
  always_ff @(posedge clk) begin
    if (rst) begin
      done_sh <= '0;
      pass_sh <= '0;
      mends_q <= 1'b0;
      for (int k = 0; k < N_CH; k++) num_sh[k] <= '0;
    end else if (state == RUN || state == DRAIN) begin
      mends_q <= |mon.mends;
      for (int k = 0; k < N_CH; k++) begin
        if (mon.rf_we[k] && mon.rf_waddr[5*k +: 5] != 5'd0) begin
          if (mon.rf_waddr[5*k +: 5] == DONE_IDX) done_sh[k] <= (mon.rf_wdata[32*k +: 32] == 32'd1);
          if (mon.rf_waddr[5*k +: 5] == PASS_IDX) pass_sh[k] <= (mon.rf_wdata[32*k +: 32] == 32'd1);
          if (mon.rf_waddr[5*k +: 5] == NUM_IDX)  num_sh[k]  <= mon.rf_wdata[32*k +: 32];
        end
      end
    end
  end

  // Reset/trap sequencing, end detection and registered verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HOLD;
      hold_cnt      <= '0;
      cnt           <= '0;
      drain_cnt     <= '0;
      done_chk      <= 1'b0;
      mends_hit     <= 1'b0;
      mon.soc_rst_n <= 1'b0;
      mon.ex_trap   <= 1'b0;
      mon.done      <= 1'b0;
      mon.pass      <= 1'b0;
      mon.fail      <= 1'b0;
      mon.timeout   <= 1'b0;
      mon.mends_end <= 1'b0;
      mon.fail_ch   <= '0;
      mon.fail_num  <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == RST_LAST) begin
            state         <= RUN;
            mon.soc_rst_n <= 1'b1;
            cnt           <= '0;
            mon.ex_trap   <= in_win('0);
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        RUN: begin
          cnt         <= cnt + CW'(1);
          mon.ex_trap <= in_win(cnt_nxt);
          // An end seen on the final cycle still beats the timeout
          if (end_now) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            done_chk  <= (ISA_TEST != 0) && all_done;
            mends_hit <= mends_q;
          end else if (cnt == TO_LAST) begin
            state       <= DONE;
            mon.ex_trap <= 1'b0;
            mon.done    <= 1'b1;
            mon.timeout <= 1'b1;
          end
        end
        DRAIN: begin
          // Keep counting so a pending trap pulse runs to completion
          if (cnt != '1) cnt <= cnt + CW'(1);
          mon.ex_trap <= in_win(cnt_nxt);
          if (drain_cnt == DR_LAST) begin
            state         <= DONE;
            mon.ex_trap   <= 1'b0;
            mon.done      <= 1'b1;
            mon.mends_end <= mends_hit;
            if (done_chk) begin
              mon.fail_ch  <= fail_mask;
              mon.fail     <= |fail_mask;
              mon.pass     <= ~(|fail_mask);
              mon.fail_num <= first_num;
            end
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_test_monitor.sv
// Scoreboard bench for sim_test_monitor: expected verdicts are queued as stimulus is driven.
// Bench cycle c is 0 on the first sample with soc_rst_n high and tracks the DUT run counter.
// A verdict registered on the edge where the counter is N is therefore observed at c = N+1.
module tb_sim_test_monitor;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic sel_b;
  int   c;
  int   n_chk;
  int   n_fail;

  typedef struct {
    int          cyc;
    logic        pass;
    logic        fail;
    logic        tmo;
    logic        mends;
    logic [1:0]  fch;
    logic [31:0] num;
  } exp_t;

  exp_t sb_q[$];

  sim_test_monitor_if #(.N_CH(2)) if_a ();
  sim_test_monitor_if #(.N_CH(1)) if_b ();

  sim_test_monitor #(.N_CH(2), .ISA_TEST(1), .TIMEOUT(200)) u_a (
    .clk (clk),
    .rst (rst_a),
    .mon (if_a.slave)
  );

  sim_test_monitor #(.N_CH(1), .ISA_TEST(0), .TIMEOUT(200)) u_b (
    .clk (clk),
    .rst (rst_b),
    .mon (if_b.slave)
  );

  logic        obs_soc, obs_trap, obs_done, obs_pass, obs_fail, obs_tmo, obs_mends;
  logic [1:0]  obs_fch;
  logic [31:0] obs_num;

  assign obs_soc   = sel_b ? if_b.soc_rst_n : if_a.soc_rst_n;
  assign obs_trap  = sel_b ? if_b.ex_trap   : if_a.ex_trap;
  assign obs_done  = sel_b ? if_b.done      : if_a.done;
  assign obs_pass  = sel_b ? if_b.pass      : if_a.pass;
  assign obs_fail  = sel_b ? if_b.fail      : if_a.fail;
  assign obs_tmo   = sel_b ? if_b.timeout   : if_a.timeout;
  assign obs_mends = sel_b ? if_b.mends_end : if_a.mends_end;
  assign obs_fch   = sel_b ? {1'b0, if_b.fail_ch} : if_a.fail_ch;
  assign obs_num   = sel_b ? if_b.fail_num  : if_a.fail_num;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (c=%0d)", tag, got, exp, c);
    end
  endtask

  function automatic logic exp_trap(input int cc);
    return (cc >= 30) && (cc <= 36);
  endfunction

  // One clock; writes last exactly one cycle
  task automatic step();
    @(posedge clk);
    #1;
    c++;
    if_a.rf_we = '0;
    if_b.rf_we = '0;
  endtask

  task automatic tick();
    step();
    check("trap", obs_trap, exp_trap(c));
    check("no_early_done", obs_done, 1'b0);
  endtask

  task automatic run_to(input int t);
    while (c < t) tick();
  endtask

  task automatic set_wr(input int ch, input logic [4:0] a, input logic [31:0] d);
    if (sel_b) begin
      if_b.rf_we[0]       = 1'b1;
      if_b.rf_waddr[4:0]  = a;
      if_b.rf_wdata[31:0] = d;
    end else begin
      if_a.rf_we[ch]          = 1'b1;
      if_a.rf_waddr[5*ch +: 5]  = a;
      if_a.rf_wdata[32*ch +: 32] = d;
    end
  endtask

  task automatic push(input int cyc, input logic p, input logic f, input logic t, input logic m,
                      input logic [1:0] fch, input logic [31:0] num);
    exp_t e;
    e.cyc = cyc; e.pass = p; e.fail = f; e.tmo = t; e.mends = m; e.fch = fch; e.num = num;
    sb_q.push_back(e);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_soc"},   obs_soc,   1'b0);
    check({tag, "_trap"},  obs_trap,  1'b0);
    check({tag, "_done"},  obs_done,  1'b0);
    check({tag, "_pass"},  obs_pass,  1'b0);
    check({tag, "_fail"},  obs_fail,  1'b0);
    check({tag, "_tmo"},   obs_tmo,   1'b0);
    check({tag, "_mends"}, obs_mends, 1'b0);
    check({tag, "_fch"},   obs_fch,   2'b00);
    check({tag, "_num"},   obs_num,   32'd0);
  endtask

  // Reset the selected DUT for 3 cycles, then measure the SoC reset width
  task automatic start_run(input logic b);
    int n;
    sel_b = b;
    if (b) rst_b = 1'b1; else rst_a = 1'b1;
    repeat (3) step();
    check_idle("rst");
    if (b) rst_b = 1'b0; else rst_a = 1'b0;
    n = 0;
    while (obs_soc !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("soc_rst_len", n, 10);
    c = 0;
    check("trap", obs_trap, exp_trap(c));
  endtask

  // Wait for done, pop the oldest expectation and compare the whole verdict
  task automatic wait_verdict(input int budget);
    exp_t e;
    int   n;
    n = 0;
    while (obs_done !== 1'b1 && n < budget) begin
      step();
      check("trap", obs_trap, exp_trap(c));
      n++;
    end
    check("verdict_seen", obs_done, 1'b1);
    check("sb_size", sb_q.size(), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check("verdict_cyc", c, e.cyc);
    check("pass",  obs_pass,  e.pass);
    check("fail",  obs_fail,  e.fail);
    check("tmo",   obs_tmo,   e.tmo);
    check("mends", obs_mends, e.mends);
    check("fch",   obs_fch,   e.fch);
    check("num",   obs_num,   e.num);
    check("soc_high", obs_soc, 1'b1);
    repeat (3) step();
    check("done_sticky", obs_done, 1'b1);
    check("pass_sticky", obs_pass, e.pass);
    check("fail_sticky", obs_fail, e.fail);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; c = 0;
    sel_b = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    if_a.rf_we = '0; if_a.rf_waddr = '0; if_a.rf_wdata = '0; if_a.mends = '0;
    if_b.rf_we = '0; if_b.rf_waddr = '0; if_b.rf_wdata = '0; if_b.mends = '0;

    // Reset width, trap window 30..36, pass: done write on cnt 100 -> verdict edge at cnt 111
    start_run(1'b0);
    run_to(98);
    set_wr(0, 5'd27, 32'd1); set_wr(1, 5'd27, 32'd1);
    run_to(100);
    set_wr(0, 5'd26, 32'd1); set_wr(1, 5'd26, 32'd1);
    push(112, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0);
    wait_verdict(100);

    // Channel 1 fails with test number 5; ch0 done early must not end the run alone
    start_run(1'b0);
    run_to(50);
    set_wr(0, 5'd26, 32'd1);
    run_to(60);
    set_wr(0, 5'd27, 32'd1); set_wr(1, 5'd3, 32'd5);
    run_to(61);
    set_wr(0, 5'd3, 32'd9); set_wr(1, 5'd27, 32'd0);
    run_to(70);
    set_wr(1, 5'd26, 32'd1);
    push(82, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 32'd5);
    wait_verdict(100);

    // Both fail (pass reg 2 is not 1): lowest channel supplies the number
    start_run(1'b0);
    run_to(20);
    set_wr(0, 5'd27, 32'd2); set_wr(1, 5'd3, 32'd5);
    run_to(21);
    set_wr(0, 5'd3, 32'd7);
    run_to(40);
    set_wr(0, 5'd26, 32'd1); set_wr(1, 5'd26, 32'd1);
    push(52, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 32'd7);
    wait_verdict(100);

    // No end at all: timeout on cnt 199
    start_run(1'b0);
    push(200, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'd0);
    run_to(150);
    wait_verdict(100);

    // Done and mends in the same cycle: judged as done, mends also flagged
    start_run(1'b0);
    run_to(5);
    set_wr(0, 5'd27, 32'd1); set_wr(1, 5'd27, 32'd1);
    run_to(80);
    set_wr(0, 5'd26, 32'd1); set_wr(1, 5'd26, 32'd1);
    if_a.mends[1] = 1'b1;
    push(92, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'd0);
    wait_verdict(100);
    if_a.mends = '0;

    // End detected on the timeout cycle: end wins, verdict 10 cycles later
    start_run(1'b0);
    run_to(10);
    set_wr(0, 5'd27, 32'd1); set_wr(1, 5'd27, 32'd1);
    run_to(198);
    set_wr(0, 5'd26, 32'd1); set_wr(1, 5'd26, 32'd1);
    push(210, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0);
    wait_verdict(100);

    // Reset mid-drain clears everything next cycle, then a clean rerun passes
    start_run(1'b0);
    run_to(98);
    set_wr(0, 5'd27, 32'd1); set_wr(1, 5'd27, 32'd1);
    run_to(100);
    set_wr(0, 5'd26, 32'd1); set_wr(1, 5'd26, 32'd1);
    run_to(105);
    rst_a = 1'b1;
    step();
    check_idle("mid_drain_rst");
    start_run(1'b0);
    run_to(98);
    set_wr(0, 5'd27, 32'd1); set_wr(1, 5'd27, 32'd1);
    run_to(100);
    set_wr(0, 5'd26, 32'd1); set_wr(1, 5'd26, 32'd1);
    push(112, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0);
    wait_verdict(100);

    // Software mode: done write ignored, mends on cnt 50 -> verdict edge at cnt 61
    start_run(1'b1);
    run_to(20);
    set_wr(0, 5'd27, 32'd1);
    run_to(21);
    set_wr(0, 5'd26, 32'd1);
    run_to(50);
    if_b.mends[0] = 1'b1;
    push(62, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'd0);
    wait_verdict(100);
    if_b.mends = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
